// File: rtl/mch_pkg.sv
// Shared definitions for the Manchester frame timing path: segment codes and
// elaboration-time helpers for frame length and bit-index width.
package mch_pkg;

  typedef enum logic [1:0] {
    PH_PRE  = 2'd0,
    PH_DATA = 2'd1,
    PH_POST = 2'd2,
    PH_IDLE = 2'd3
  } phase_e;

  function automatic int total_bits(input int pre_bits, input int data_bits, input int post_bits);
    return pre_bits + data_bits + post_bits;
  endfunction

  function automatic int bit_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/mch_start_sync.sv
// Three-flop synchronizer for an asynchronous level input with a registered
// rising-edge pulse output. Shared by the encoder and decoder timing paths.
module mch_start_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;
  logic r_edge;

  // Edge pulse is registered so a launch lands on the fourth edge after the
  // input is first sampled high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_edge  <= r_sync2 & ~r_sync3;
    end
  end

  assign o_edge = r_edge;

endmodule

// File: rtl/mch_frame_timer.sv
// Frame timing controller: quarter-bit divider, bit counter and segment code
// for a PRE/DATA/POST frame, with abort, looping and retrigger policy.
module mch_frame_timer
  import mch_pkg::*;
#(
  parameter int DIV       = 25,
  parameter int PRE_BITS  = 12,
  parameter int DATA_BITS = 56,
  parameter int POST_BITS = 12,
  parameter int RETRIG    = 0,
  localparam int TOTAL    = total_bits(PRE_BITS, DATA_BITS, POST_BITS),
  localparam int BIT_W    = bit_width(TOTAL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             loop,
  output logic [1:0]       phase,
  output logic [BIT_W-1:0] bit_idx,
  output logic             pls1m,
  output logic             pls2m,
  output logic             bit_stb,
  output logic             busy,
  output logic             done
);

  localparam int DIV_W = $clog2(DIV);
  localparam logic [DIV_W-1:0] QDIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] QDIV_ONE   = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);
  localparam logic [BIT_W-1:0] PRE_LAST   = BIT_W'(PRE_BITS - 1);
  localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(PRE_BITS + DATA_BITS - 1);
  localparam logic [BIT_W-1:0] FRAME_LAST = BIT_W'(TOTAL - 1);

  phase_e           r_phase;
  logic [DIV_W-1:0] r_qdiv;
  logic [1:0]       r_qq;
  logic [BIT_W-1:0] r_bit_idx;
  logic             r_bit_stb;
  logic             r_done;

  logic w_sedge;
  logic w_busy;
  logic w_eob;
  logic w_last;
  logic w_take;

  mch_start_sync u_start_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (start),
    .o_edge  (w_sedge)
  );

  assign w_busy = (r_phase != PH_IDLE);
  assign w_eob  = (r_qdiv == QDIV_LAST) && (r_qq == 2'd3);
  assign w_last = w_eob && (r_bit_idx == FRAME_LAST);
  // A start edge launches from idle; while busy it only restarts when retrigger is enabled.
  assign w_take = w_sedge && (!w_busy || (RETRIG != 0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase   <= PH_IDLE;
      r_qdiv    <= '0;
      r_qq      <= 2'd3;
      r_bit_idx <= '0;
      r_bit_stb <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_bit_stb <= 1'b0;
      r_done    <= 1'b0;
      if (abort) begin
        r_phase   <= PH_IDLE;
        r_qdiv    <= '0;
        r_qq      <= 2'd3;
        r_bit_idx <= '0;
      end else if (w_take) begin
        r_phase   <= PH_PRE;
        r_qdiv    <= '0;
        r_qq      <= 2'd0;
        r_bit_idx <= '0;
        r_bit_stb <= 1'b1;
      end else if (w_busy) begin
        if (w_last) begin
          r_done    <= 1'b1;
          r_qdiv    <= '0;
          r_bit_idx <= '0;
          if (loop) begin
            r_phase   <= PH_PRE;
            r_qq      <= 2'd0;
            r_bit_stb <= 1'b1;
          end else begin
            r_phase   <= PH_IDLE;
            r_qq      <= 2'd3;
          end
        end else if (w_eob) begin
          r_qdiv    <= '0;
          r_qq      <= 2'd0;
          r_bit_idx <= r_bit_idx + BIT_ONE;
          r_bit_stb <= 1'b1;
          if (r_bit_idx == PRE_LAST) begin
            r_phase <= PH_DATA;
          end else if (r_bit_idx == DATA_LAST) begin
            r_phase <= PH_POST;
          end
        end else if (r_qdiv == QDIV_LAST) begin
          r_qdiv <= '0;
          r_qq   <= r_qq + 2'd1;
        end else begin
          r_qdiv <= r_qdiv + QDIV_ONE;
        end
      end
    end
  end

  assign phase   = r_phase;
  assign bit_idx = r_bit_idx;
  assign pls1m   = r_qq[1];
  assign pls2m   = r_qq[0];
  assign bit_stb = r_bit_stb;
  assign busy    = w_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_mch_frame_timer.sv
// Bench for mch_frame_timer: default-size instance plus two small instances
// (ignore / restart retrigger) checked by tables, directed runs and a model.
module tb_mch_frame_timer;

  localparam int NDUT = 3;
  localparam int IDLE_VEC   = (3 << 13) | (3 << 3);
  localparam int LAUNCH_VEC = (1 << 2) | (1 << 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic a_start = 1'b0, a_abort = 1'b0, a_loop = 1'b0;
  logic bc_start = 1'b0, bc_abort = 1'b0, bc_loop = 1'b0;

  logic [1:0] a_phase, b_phase, c_phase;
  logic [6:0] a_bit;
  logic [2:0] b_bit, c_bit;
  logic a_p1, a_p2, a_stb, a_busy, a_done;
  logic b_p1, b_p2, b_stb, b_busy, b_done;
  logic c_p1, c_p2, c_stb, c_busy, c_done;

  mch_frame_timer u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .loop(a_loop),
    .phase(a_phase), .bit_idx(a_bit), .pls1m(a_p1), .pls2m(a_p2),
    .bit_stb(a_stb), .busy(a_busy), .done(a_done)
  );

  mch_frame_timer #(.DIV(2), .PRE_BITS(2), .DATA_BITS(3), .POST_BITS(1), .RETRIG(0)) u_dut_b (
    .clk(clk), .rst(rst), .start(bc_start), .abort(bc_abort), .loop(bc_loop),
    .phase(b_phase), .bit_idx(b_bit), .pls1m(b_p1), .pls2m(b_p2),
    .bit_stb(b_stb), .busy(b_busy), .done(b_done)
  );

  mch_frame_timer #(.DIV(2), .PRE_BITS(2), .DATA_BITS(3), .POST_BITS(1), .RETRIG(1)) u_dut_c (
    .clk(clk), .rst(rst), .start(bc_start), .abort(bc_abort), .loop(bc_loop),
    .phase(c_phase), .bit_idx(c_bit), .pls1m(c_p1), .pls2m(c_p2),
    .bit_stb(c_stb), .busy(c_busy), .done(c_done)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit model_on = 1'b0;

  int p_div    [NDUT] = '{25, 2, 2};
  int p_pre    [NDUT] = '{12, 2, 2};
  int p_data   [NDUT] = '{56, 3, 3};
  int p_post   [NDUT] = '{12, 1, 1};
  int p_retrig [NDUT] = '{0, 0, 1};

  bit       m_active [NDUT];
  int       m_t      [NDUT];
  bit [3:0] m_hist   [NDUT];
  bit       m_stb    [NDUT];
  bit       m_done   [NDUT];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Packed view: phase[14:13] bit_idx[12:5] pls1m pls2m bit_stb busy done.
  function automatic int dut_vec(input int i);
    logic [14:0] v;
    case (i)
      0:       v = {a_phase, 8'(a_bit), a_p1, a_p2, a_stb, a_busy, a_done};
      1:       v = {b_phase, 8'(b_bit), b_p1, b_p2, b_stb, b_busy, b_done};
      default: v = {c_phase, 8'(c_bit), c_p1, c_p2, c_stb, c_busy, c_done};
    endcase
    return int'(v);
  endfunction

  // Reference: one position counter t across the frame; everything else is
  // derived from it by division.
  function automatic int model_vec(input int i);
    int bit_n, q, ph;
    if (!m_active[i]) return IDLE_VEC | (int'(m_stb[i]) << 2) | int'(m_done[i]);
    bit_n = m_t[i] / (4 * p_div[i]);
    q     = (m_t[i] / p_div[i]) % 4;
    ph    = (bit_n < p_pre[i]) ? 0 : (bit_n < p_pre[i] + p_data[i]) ? 1 : 2;
    return (ph << 13) | (bit_n << 5) | (q << 3) | (int'(m_stb[i]) << 2) | (1 << 1) | int'(m_done[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      m_active[i] = 1'b0; m_t[i] = 0; m_hist[i] = 4'd0; m_stb[i] = 1'b0; m_done[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NDUT; i++) begin
      logic s, ab, lp, req;
      int frame;
      s  = (i == 0) ? a_start : bc_start;
      ab = (i == 0) ? a_abort : bc_abort;
      lp = (i == 0) ? a_loop  : bc_loop;
      frame = 4 * p_div[i] * (p_pre[i] + p_data[i] + p_post[i]);
      req = m_hist[i][2] & ~m_hist[i][3];
      m_hist[i] = {m_hist[i][2:0], s};
      m_done[i] = 1'b0;
      m_stb[i]  = 1'b0;
      if (ab) begin
        m_active[i] = 1'b0;
      end else if (req && (!m_active[i] || p_retrig[i] != 0)) begin
        m_active[i] = 1'b1; m_t[i] = 0; m_stb[i] = 1'b1;
      end else if (m_active[i]) begin
        if (m_t[i] == frame - 1) begin
          m_done[i] = 1'b1;
          if (lp) begin m_t[i] = 0; m_stb[i] = 1'b1; end
          else m_active[i] = 1'b0;
        end else begin
          m_t[i]++;
          m_stb[i] = (m_t[i] % (4 * p_div[i])) == 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_step();
    else model_reset();
    @(negedge clk);
    if (model_on) begin
      for (int i = 0; i < NDUT; i++) check($sformatf("model_dut%0d", i), dut_vec(i), model_vec(i));
    end
  endtask

  typedef struct {
    bit       start;
    bit [1:0] ph;
    int       bidx;
    bit [1:0] pls;
    bit       stb;
    bit       busy;
  } vec_t;

  vec_t tbl [20];

  initial begin
    int k, prev, n_done, n_idle, n_wrap, n_stb;
    int t_data, t_post, t_idle, t_done, s_b, s_c;
    tbl[0]  = '{1, 3, 0, 3, 0, 0}; tbl[1]  = '{1, 3, 0, 3, 0, 0};
    tbl[2]  = '{1, 3, 0, 3, 0, 0}; tbl[3]  = '{0, 0, 0, 0, 1, 1};
    tbl[4]  = '{0, 0, 0, 0, 0, 1}; tbl[5]  = '{0, 0, 0, 1, 0, 1};
    tbl[6]  = '{0, 0, 0, 1, 0, 1}; tbl[7]  = '{0, 0, 0, 2, 0, 1};
    tbl[8]  = '{0, 0, 0, 2, 0, 1}; tbl[9]  = '{0, 0, 0, 3, 0, 1};
    tbl[10] = '{0, 0, 0, 3, 0, 1}; tbl[11] = '{0, 0, 1, 0, 1, 1};
    tbl[12] = '{0, 0, 1, 0, 0, 1}; tbl[13] = '{0, 0, 1, 1, 0, 1};
    tbl[14] = '{0, 0, 1, 1, 0, 1}; tbl[15] = '{0, 0, 1, 2, 0, 1};
    tbl[16] = '{0, 0, 1, 2, 0, 1}; tbl[17] = '{0, 0, 1, 3, 0, 1};
    tbl[18] = '{0, 0, 1, 3, 0, 1}; tbl[19] = '{0, 1, 2, 0, 1, 1};
    model_reset();

    // Reset values
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) check($sformatf("reset_dut%0d", i), dut_vec(i), IDLE_VEC);
    rst = 1'b1;
    step(); step();
    check("idle_after_reset_b", dut_vec(1), IDLE_VEC);

    // Launch latency and quarter pattern on the small instance
    for (int r = 0; r < 20; r++) begin
      bc_start = tbl[r].start;
      step();
      check($sformatf("tbl_row%0d", r), dut_vec(1),
            int'({tbl[r].ph, 8'(tbl[r].bidx), tbl[r].pls, tbl[r].stb, tbl[r].busy, 1'b0}));
      $display("row %0d: phase=%0d bit=%0d pls=%0d%0d stb=%0d", r, b_phase, b_bit, b_p1, b_p2, b_stb);
    end
    k = 0; prev = 0;
    while (!b_done && k < 40) begin prev = int'(b_bit); step(); k++; end
    check("small_done_time", k, 32);
    check("small_last_bit", prev, 5);
    check("small_done_vec", dut_vec(1), IDLE_VEC | 1);

    // Default instance: full frame timing
    a_start = 1'b1;
    step(); step(); step();
    check("a_idle_after_e3", int'(a_phase), 3);
    a_start = 1'b0;
    step();
    check("a_launch_e4", dut_vec(0), LAUNCH_VEC);
    t_data = -1; t_post = -1; t_idle = -1; t_done = -1; n_stb = 1; n_done = 0;
    for (int t = 1; t <= 8010 && t_idle < 0; t++) begin
      step();
      if (a_phase == 2'd1 && t_data < 0) t_data = t;
      if (a_phase == 2'd2 && t_post < 0) t_post = t;
      if (a_phase == 2'd3 && t_idle < 0) t_idle = t;
      if (a_stb) n_stb++;
      if (a_done) begin n_done++; t_done = t; end
    end
    check("a_t_data", t_data, 1200);
    check("a_t_post", t_post, 6800);
    check("a_t_idle", t_idle, 8000);
    check("a_t_done", t_done, 8000);
    check("a_n_done", n_done, 1);
    check("a_n_stb", n_stb, 80);
    $display("default frame: data@%0d post@%0d idle@%0d strobes=%0d", t_data, t_post, t_idle, n_stb);

    // Abort in DATA bit 3
    bc_start = 1'b1; k = 0;
    while (!b_busy && k < 10) begin step(); k++; end
    bc_start = 1'b0;
    check("abort_launch", int'(b_busy), 1);
    k = 0;
    while (b_bit != 3'd3 && k < 60) begin step(); k++; end
    check("abort_at_data3", int'(b_phase), 1);
    bc_abort = 1'b1;
    step();
    bc_abort = 1'b0;
    check("abort_idle_vec", dut_vec(1), IDLE_VEC);
    n_done = 0;
    for (int i = 0; i < 5; i++) begin step(); if (b_done) n_done++; end
    check("abort_no_done", n_done, 0);

    // Back-to-back looping
    bc_loop = 1'b1; bc_start = 1'b1; k = 0;
    while (!b_busy && k < 10) begin step(); k++; end
    bc_start = 1'b0;
    check("loop_launch", int'(b_busy), 1);
    n_done = 0; n_idle = 0; n_wrap = 0; prev = 0; k = 0;
    while (n_done < 3 && k < 200) begin
      prev = int'(b_bit);
      step(); k++;
      if (b_done) begin
        n_done++;
        if (n_done < 3) check("loop_wrap_vec", dut_vec(1), LAUNCH_VEC | 1);
        if (n_done == 2) bc_loop = 1'b0;
      end else if (!b_busy) n_idle++;
      if (b_busy && prev == 5 && b_bit == 3'd0) n_wrap++;
    end
    check("loop_len", k, 144);
    check("loop_n_wrap", n_wrap, 2);
    check("loop_no_idle", n_idle, 0);
    check("loop_end_vec", dut_vec(1), IDLE_VEC | 1);

    // Start edge mid-frame: B ignores, C restarts
    bc_start = 1'b1; k = 0;
    while (!b_busy && k < 10) begin step(); k++; end
    bc_start = 1'b0; k = 0;
    while (b_bit != 3'd3 && k < 40) begin step(); k++; end
    bc_start = 1'b1;
    step(); step(); step();
    check("retrig_c_before", int'(c_bit), 3);
    step();
    check("retrig_c_restart", dut_vec(2), LAUNCH_VEC);
    check("retrig_b_ignore", dut_vec(1), (1 << 13) | (3 << 5) | (2 << 3) | (1 << 1));
    bc_start = 1'b0;
    s_b = -1; s_c = -1;
    for (int s = 1; s <= 60 && s_c < 0; s++) begin
      step();
      if (b_done && s_b < 0) s_b = s;
      if (c_done && s_c < 0) s_c = s;
    end
    check("retrig_b_done", s_b, 20);
    check("retrig_c_done", s_c, 48);

    // Asynchronous reset mid-frame, then a fresh launch
    bc_start = 1'b1; k = 0;
    while (!b_busy && k < 10) begin step(); k++; end
    bc_start = 1'b0;
    repeat (10) step();
    #2 rst = 1'b0;
    #1;
    check("rst_mid_b", dut_vec(1), IDLE_VEC);
    check("rst_mid_c", dut_vec(2), IDLE_VEC);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    bc_start = 1'b1;
    step(); step(); step();
    check("rst_relaunch_e3", int'(b_busy), 0);
    step();
    check("rst_relaunch_e4", dut_vec(1), LAUNCH_VEC);
    bc_start = 1'b0;

    // Randomized run against the reference model
    rst = 1'b0;
    step();
    rst = 1'b1;
    bc_loop = 1'b0; a_start = 1'b0;
    model_on = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) bc_start = ~bc_start;
      if ($urandom_range(0, 199) == 0) a_start = ~a_start;
      bc_abort = ($urandom_range(0, 99) == 0);
      a_abort  = ($urandom_range(0, 999) == 0);
      bc_loop  = 1'($urandom_range(0, 1));
      a_loop   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b0;
        step();
        rst = 1'b1;
      end
      step();
    end
    model_on = 1'b0;
    $display("random run: %0d checks so far", n_checks);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
